// File: rtl/sram_read_streamer.sv
// Read sequencer for one RW port of a 512x8 OpenRAM macro, streaming fetched bytes out over valid/ready.
// Optional build macro STREAMER_STALL_CNT_EN adds a 16-bit saturating backpressure stall counter output.
module sram_read_streamer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef STREAMER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [PW-1:0]         PTR_ONE  = 1;
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [CW:0]           DEPTH_L  = FIFO_DEPTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [1:0]            pending;
  logic [CW:0]           used;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;

  // A read is in flight while csb is low (macro latching) and for the cycle after (data on dout).
  assign pending   = {1'b0, ~sram_csb} + {1'b0, rd_vld_p1};
  assign used      = {1'b0, fifo_count} + {{(CW-1){1'b0}}, pending};
  assign credit_ok = used < DEPTH_L;
  assign push      = rd_vld_p1;
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign sram_web  = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sram_csb  <= 1'b1;
      sram_addr <= '0;
      next_addr <= '0;
      len_q     <= '0;
      issued_q  <= '0;
    end else begin
      done     <= 1'b0;
      sram_csb <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              // The accepting edge already issues the first read; the pipeline is empty here.
              len_q     <= length;
              sram_csb  <= 1'b0;
              sram_addr <= base_addr;
              next_addr <= base_addr + ADDR_ONE;
              issued_q  <= LEN_ONE;
              busy      <= 1'b1;
              state     <= (length == LEN_ONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (credit_ok) begin
            sram_csb  <= 1'b0;
            sram_addr <= next_addr;
            next_addr <= next_addr + ADDR_ONE;
            issued_q  <= issued_q + LEN_ONE;
            if (issued_q + LEN_ONE == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pending == 2'd0 && fifo_count == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture stage: dout is valid one cycle after the macro latched the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      rd_vld_p1 <= ~sram_csb;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_dout;
  end

`ifdef STREAMER_STALL_CNT_EN
  logic start_acc;
  assign start_acc = (state == IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_read_streamer.sv
// Randomized scoreboard bench for sram_read_streamer with a behavioural 512x8 macro model.
module tb_sram_read_streamer;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          sram_csb;
  logic          sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef STREAMER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef STREAMER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  logic [7:0]    mem [512];
  logic [7:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  int total = 0;
  int bad = 0;
  int issues = 0;
  int pops = 0;
  int stall_m = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  // Macro: request latched on the edge while csb low, data valid for the following cycle only.
  always @(posedge clk) begin
    if (!sram_csb) sram_dout <= mem[sram_addr];
    else           sram_dout <= 8'($urandom);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      issues = 0; pops = 0; prev_hold = 1'b0;
      exp_q.delete(); addr_q.delete();
    end else begin
      if (!sram_csb) begin
        issues++;
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue: actual addr=%0h required=no issue", sram_addr);
        end else begin
          chk("issue_addr", 32'(sram_addr), 32'(addr_q.pop_front()));
        end
        chk("web", 32'(sram_web), 32'd1);
      end
      chk("credit_bound", 32'((issues - pops) <= DEPTH), 32'd1);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && !out_ready) stall_m++;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_data: actual=%0h required=no data", out_data);
        end else begin
          chk("data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_csb"}, 32'(sram_csb), 32'd1);
    chk({tag, "_web"}, 32'(sram_web), 32'd1);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
`ifdef STREAMER_STALL_CNT_EN
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 10 cycles mid-stream.
  task automatic run_cmd(input logic [AW-1:0] base, input int len, input int mode,
                         input bit inject, output int lat);
    int k;
    int sbase;
    int exp_stall;
    start = 1'b1;
    base_addr = base;
    length = len[AW:0];
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = AW'((int'(base) + i) % 512);
      exp_q.push_back(mem[a]);
      addr_q.push_back(a);
    end
    out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sbase = stall_m;
    if (len == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
    end else begin
      chk("accept_busy", 32'(busy), 32'd1);
      chk("first_issue_csb", 32'(sram_csb), 32'd0);
      chk("first_issue_addr", 32'(sram_addr), 32'(base));
      chk("done_early", 32'(done), 32'd0);
    end
    k = 0;
    while (!done && k < 4 * len + 64) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(k >= 4 && k <= 13);
      endcase
      if (inject) begin
        start = (k == 3);
        if (k == 3) begin
          base_addr = base + 9'd100;
          length = 10'd5;
        end
      end
      @(posedge clk); #1;
      k++;
      if (mode == 0 && k == 1) chk("valid_after_e1", 32'(out_valid), 32'd0);
      if (mode == 0 && k == 2) chk("valid_after_e2", 32'(out_valid), 32'd1);
      if (mode == 2 && k == 13) chk("outstanding_max", 32'(issues - pops), 32'(DEPTH));
    end
    start = 1'b0;
    lat = k;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    exp_stall = (stall_m - sbase > 65535) ? 65535 : stall_m - sbase;
`ifdef STREAMER_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`else
    if (mode == 2) chk("stall_cycles_seen", 32'(exp_stall), 32'd10);
`endif
  endtask

  initial begin
    int lat;
    int len;
    int mode;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(9'h010, 8, 0, 1'b0, lat);
    chk("full_rate_latency", 32'(lat), 32'd11);

    run_cmd(9'h1FE, 4, 0, 1'b0, lat);
    chk("wrap_latency", 32'(lat), 32'd7);

    run_cmd(9'h040, 16, 2, 1'b0, lat);

    run_cmd(9'h033, 0, 0, 1'b0, lat);
    @(posedge clk); #1;
    chk("zero_done_pulse_end", 32'(done), 32'd0);
    chk("zero_busy_after", 32'(busy), 32'd0);

    run_cmd(9'h0A0, 12, 0, 1'b1, lat);
    chk("ignored_start_latency", 32'(lat), 32'd15);

    // Reset two cycles after the first issue of a running command.
    start = 1'b1; base_addr = 9'h080; length = 10'd20; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mem[9'h080 + i]);
      addr_q.push_back(AW'(9'h080 + i));
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cmd(9'h100, 2, 0, 1'b0, lat);
    chk("post_reset_latency", 32'(lat), 32'd5);

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 30; n++) begin
      len = (n == 15) ? 512 : $urandom_range(0, 40);
      mode = $urandom_range(0, 1);
      run_cmd(AW'($urandom), len, mode, 1'b0, lat);
      if (mode == 0 && len != 0) chk("random_latency", 32'(lat), 32'(len + 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
